// File: rtl/sobel_gradient_pkg.sv
// Shared constants for the Sobel gradient stage and its line buffers.
// The downstream magnitude/threshold stage imports the same widths.
package sobel_gradient_pkg;

    localparam int SOBEL_IMG_WIDTH = 640;
    localparam int SOBEL_PIX_W     = 8;
    localparam int SOBEL_GRAD_W    = 12;
    localparam int WIN_N           = 3;

    // Address/counter width that stays legal for a depth of 1.
    function automatic int cnt_bits(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// Fixed-length pixel delay line: o_dout is the pixel written DEPTH enables ago.
// Read-before-write on a wrapping address counter so it maps onto block RAM.
module sobel_line_buffer
    import sobel_gradient_pkg::*;
#(
    parameter int DEPTH = SOBEL_IMG_WIDTH,
    parameter int WIDTH = SOBEL_PIX_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout
);

    localparam int AW = cnt_bits(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_addr;
    logic [WIDTH-1:0] r_dout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr <= '0;
        end else if (i_en) begin
            r_addr <= (r_addr == AW'(DEPTH - 1)) ? '0 : r_addr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_en) begin
            r_dout        <= r_mem[r_addr];
            r_mem[r_addr] <= i_din;
        end
    end

    assign o_dout = r_dout;

endmodule

// File: rtl/sobel_gradient.sv
// Streaming 3x3 Sobel gradient: two cascaded line buffers feed a 3x3 window,
// adder tree produces signed Dx/Dy two cycles after each accepted pixel.
module sobel_gradient
    import sobel_gradient_pkg::*;
#(
    parameter int IMG_WIDTH = SOBEL_IMG_WIDTH,
    parameter int PIX_W     = SOBEL_PIX_W,
    parameter int GRAD_W    = SOBEL_GRAD_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     sof,
    input  logic                     pix_valid,
    input  logic [PIX_W-1:0]         pix_in,
    output logic signed [GRAD_W-1:0] Dx_reg,
    output logic signed [GRAD_W-1:0] Dy_reg,
    output logic                     grad_valid
);

    localparam int COL_W = cnt_bits(IMG_WIDTH);

    logic [COL_W-1:0] r_col, w_col;
    logic [1:0]       r_row, w_row;
    logic             w_pos_ok;

    logic [PIX_W-1:0] r_pix;
    logic             r_acc, r_pos_ok, r_win_ok;
    logic [PIX_W-1:0] w_lb0, w_lb1;
    logic [PIX_W-1:0] w_newcol [WIN_N];
    logic [PIX_W-1:0] w_p      [WIN_N][WIN_N];

    logic [GRAD_W-1:0]        w_sum_right, w_sum_left, w_sum_bot, w_sum_top;
    logic signed [GRAD_W-1:0] w_dx, w_dy;

    // sof overrides the counters for the pixel it qualifies.
    always_comb begin
        w_col    = sof ? '0 : r_col;
        w_row    = sof ? '0 : r_row;
        w_pos_ok = (w_row == 2'd2) && (w_col >= COL_W'(2));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col <= '0;
            r_row <= '0;
        end else if (pix_valid) begin
            if (w_col == COL_W'(IMG_WIDTH - 1)) begin
                r_col <= '0;
                r_row <= (w_row == 2'd2) ? 2'd2 : w_row + 2'd1;
            end else begin
                r_col <= w_col + 1'b1;
                r_row <= w_row;
            end
        end
    end

    // Second buffer is one short because its input is already one accept late.
    sobel_line_buffer #(.DEPTH(IMG_WIDTH),     .WIDTH(PIX_W)) u_lb0 (
        .clk(clk), .rst_n(rst_n), .i_en(pix_valid), .i_din(pix_in), .o_dout(w_lb0)
    );
    sobel_line_buffer #(.DEPTH(IMG_WIDTH - 1), .WIDTH(PIX_W)) u_lb1 (
        .clk(clk), .rst_n(rst_n), .i_en(pix_valid), .i_din(w_lb0), .o_dout(w_lb1)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pix    <= '0;
            r_acc    <= 1'b0;
            r_pos_ok <= 1'b0;
        end else begin
            r_acc    <= pix_valid;
            r_pos_ok <= pix_valid && w_pos_ok;
            if (pix_valid) begin
                r_pix <= pix_in;
            end
        end
    end

    assign w_newcol[0] = w_lb1;
    assign w_newcol[1] = w_lb0;
    assign w_newcol[2] = r_pix;

    for (genvar gi = 0; gi < WIN_N; gi++) begin : g_row
        logic [PIX_W-1:0] r_px [WIN_N];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int c = 0; c < WIN_N; c++) begin
                    r_px[c] <= '0;
                end
            end else if (r_acc) begin
                for (int c = 0; c < WIN_N - 1; c++) begin
                    r_px[c] <= r_px[c+1];
                end
                r_px[WIN_N-1] <= w_newcol[gi];
            end
        end

        for (genvar gj = 0; gj < WIN_N; gj++) begin : g_col
            assign w_p[gi][gj] = r_px[gj];
        end
    end

    always_comb begin
        w_sum_right = GRAD_W'(w_p[0][2]) + (GRAD_W'(w_p[1][2]) << 1) + GRAD_W'(w_p[2][2]);
        w_sum_left  = GRAD_W'(w_p[0][0]) + (GRAD_W'(w_p[1][0]) << 1) + GRAD_W'(w_p[2][0]);
        w_sum_bot   = GRAD_W'(w_p[2][0]) + (GRAD_W'(w_p[2][1]) << 1) + GRAD_W'(w_p[2][2]);
        w_sum_top   = GRAD_W'(w_p[0][0]) + (GRAD_W'(w_p[0][1]) << 1) + GRAD_W'(w_p[0][2]);
        w_dx        = signed'(w_sum_right - w_sum_left);
        w_dy        = signed'(w_sum_bot - w_sum_top);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_win_ok   <= 1'b0;
            grad_valid <= 1'b0;
            Dx_reg     <= '0;
            Dy_reg     <= '0;
        end else begin
            r_win_ok   <= r_acc && r_pos_ok;
            grad_valid <= r_win_ok;
            if (r_win_ok) begin
                Dx_reg <= w_dx;
                Dy_reg <= w_dy;
            end
        end
    end

endmodule

// File: tb/tb_sobel_gradient.sv
// Directed frame tests for sobel_gradient at IMG_WIDTH=8 with 8-line frames;
// expected gradients come from hand constants or a direct convolution of the test image.
module tb_sobel_gradient;

    localparam int W  = 8;
    localparam int H  = 8;
    localparam int PW = 8;
    localparam int GW = 12;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 sof = 1'b0;
    logic                 pix_valid = 1'b0;
    logic [PW-1:0]        pix_in = '0;
    logic signed [GW-1:0] Dx_reg, Dy_reg;
    logic                 grad_valid;

    always #5 clk = ~clk;

    sobel_gradient #(.IMG_WIDTH(W), .PIX_W(PW), .GRAD_W(GW)) dut (
        .clk(clk), .rst_n(rst_n), .sof(sof), .pix_valid(pix_valid), .pix_in(pix_in),
        .Dx_reg(Dx_reg), .Dy_reg(Dy_reg), .grad_valid(grad_valid)
    );

    typedef struct { int dx; int dy; } grad_t;
    typedef struct {
        string name; int kind; int gap;
        int n_exp; int edge_n; int edge_dx; int edge_dy; int dx; int dy;
        bit use_model;
    } vec_t;

    int      n_checks = 0;
    int      n_pass   = 0;
    logic [PW-1:0] img [H][W];
    grad_t   cap_q[$];
    grad_t   exp_q[$];
    vec_t    vecs[7];

    always @(negedge clk) begin
        if (grad_valid) cap_q.push_back('{dx: int'(Dx_reg), dy: int'(Dy_reg)});
    end

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    function automatic int px(input int r, input int c);
        return int'(img[r][c]);
    endfunction

    function automatic void model_push(input int r, input int c);
        grad_t g;
        g.dx = (px(r-2,c) + 2*px(r-1,c) + px(r,c)) - (px(r-2,c-2) + 2*px(r-1,c-2) + px(r,c-2));
        g.dy = (px(r,c-2) + 2*px(r,c-1) + px(r,c)) - (px(r-2,c-2) + 2*px(r-2,c-1) + px(r-2,c));
        exp_q.push_back(g);
    endfunction

    function automatic void model_frame();
        for (int r = 2; r < H; r++)
            for (int c = 2; c < W; c++) model_push(r, c);
    endfunction

    task automatic fill(input int kind);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                case (kind)
                    0: img[r][c] = 8'd100;
                    1: img[r][c] = 8'(c * 10);
                    2: img[r][c] = (r >= 2) ? 8'd255 : 8'd0;
                    3: img[r][c] = (r >= 2) ? 8'd0 : 8'd255;
                    4: img[r][c] = 8'($urandom);
                    default: ;
                endcase
    endtask

    task automatic send(input int npix, input int gap_pct);
        for (int k = 0; k < npix; k++) begin
            while ($urandom_range(99) < gap_pct) begin
                @(negedge clk);
                pix_valid = 1'b0;
                sof       = 1'($urandom_range(1));
                pix_in    = 8'($urandom);
            end
            @(negedge clk);
            pix_valid = 1'b1;
            sof       = (k == 0);
            pix_in    = img[k / W][k % W];
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            pix_valid = 1'b0;
            sof       = 1'b0;
        end
    endtask

    task automatic compare_all(input string name);
        check({name, " count"}, cap_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < cap_q.size()) begin
                check($sformatf("%s dx[%0d]", name, i), cap_q[i].dx, exp_q[i].dx);
                check($sformatf("%s dy[%0d]", name, i), cap_q[i].dy, exp_q[i].dy);
            end
        end
    endtask

    initial begin
        // name, kind, gap%, n_exp, edge_n, edge_dx, edge_dy, dx, dy, model
        vecs[0] = '{"flat",        0,  0, 36,  0, 0,     0,  0, 0, 1'b0};
        vecs[1] = '{"ramp",        1,  0, 36,  0, 0,     0, 80, 0, 1'b0};
        vecs[2] = '{"step",        2,  0, 36, 12, 0,  1020,  0, 0, 1'b0};
        vecs[3] = '{"inv step",    3,  0, 36, 12, 0, -1020,  0, 0, 1'b0};
        vecs[4] = '{"ramp gaps",   1, 50, 36,  0, 0,     0, 80, 0, 1'b0};
        vecs[5] = '{"random",      4,  0, 36,  0, 0,     0,  0, 0, 1'b1};
        vecs[6] = '{"random gaps", 5, 50, 36,  0, 0,     0,  0, 0, 1'b1};

        repeat (2) @(posedge clk);
        #1;
        check("reset grad_valid", int'(grad_valid), 0);
        check("reset Dx", int'(Dx_reg), 0);
        check("reset Dy", int'(Dy_reg), 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        for (int v = 0; v < 7; v++) begin
            fill(vecs[v].kind);
            cap_q.delete();
            exp_q.delete();
            if (vecs[v].use_model) model_frame();
            else
                for (int i = 0; i < vecs[v].n_exp; i++)
                    if (i < vecs[v].edge_n) exp_q.push_back('{dx: vecs[v].edge_dx, dy: vecs[v].edge_dy});
                    else                    exp_q.push_back('{dx: vecs[v].dx, dy: vecs[v].dy});
            send(W * H, vecs[v].gap);
            idle(6);
            compare_all(vecs[v].name);
            idle(3);
            check({vecs[v].name, " hold dx"}, int'(Dx_reg), exp_q[$].dx);
            check({vecs[v].name, " hold dy"}, int'(Dy_reg), exp_q[$].dy);
        end

        // sof arrives at row 3, col 4 of a running frame
        fill(4);
        cap_q.delete();
        exp_q.delete();
        for (int c = 2; c < W; c++) model_push(2, c);
        model_push(3, 2);
        model_push(3, 3);
        send(3 * W + 4, 0);
        fill(4);
        model_frame();
        send(W * H, 0);
        idle(6);
        compare_all("sof mid-line");

        // asynchronous reset while strobes are in flight
        fill(1);
        begin
            bit found = 1'b0;
            for (int k = 0; k < W * H && !found; k++) begin
                @(negedge clk);
                pix_valid = 1'b1;
                sof       = (k == 0);
                pix_in    = img[k / W][k % W];
                if (k >= 3 * W && grad_valid && Dx_reg == 12'sd80) found = 1'b1;
            end
            check("reset precondition", int'(found), 1);
        end
        #2;
        rst_n     = 1'b0;
        pix_valid = 1'b0;
        sof       = 1'b0;
        #1;
        check("async reset grad_valid", int'(grad_valid), 0);
        check("async reset Dx", int'(Dx_reg), 0);
        check("async reset Dy", int'(Dy_reg), 0);
        @(negedge clk);
        rst_n = 1'b1;
        cap_q.delete();
        exp_q.delete();
        fill(4);
        model_frame();
        send(W * H, 0);
        idle(6);
        compare_all("after reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
